// File: rtl/bp_cce_dir_read_seq.sv
// Directory way-group read sequencer: reads every directory row of one way group,
// tag-compares each returned entry and collects per-LCE hit/way/state for the GAD logic.
module bp_cce_dir_read_seq #(
    parameter int unsigned num_lce_p        = 8,
    parameter int unsigned lce_assoc_p      = 8,
    parameter int unsigned lce_per_row_p    = 2,
    parameter int unsigned tag_width_p      = 12,
    parameter int unsigned num_way_groups_p = 64,
    localparam int unsigned rows_lp         = num_lce_p / lce_per_row_p,
    localparam int unsigned entry_w_lp      = tag_width_p + 3,
    localparam int unsigned lg_rows_lp      = (rows_lp > 1) ? $clog2(rows_lp) : 1,
    localparam int unsigned lg_wg_lp        = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
    localparam int unsigned lg_lce_assoc_lp = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int unsigned row_w_lp        = lce_per_row_p * lce_assoc_p * entry_w_lp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  start_v_i,
    output logic                                  ready_o,
    input  logic [lg_wg_lp-1:0]                   wg_i,
    input  logic [tag_width_p-1:0]                tag_i,
    output logic                                  dir_r_v_o,
    input  logic                                  dir_r_ready_i,
    output logic [lg_wg_lp+lg_rows_lp-1:0]        dir_addr_o,
    input  logic [row_w_lp-1:0]                   dir_data_i,
    output logic                                  sharers_v_o,
    output logic                                  gad_v_o,
    input  logic                                  yumi_i,
    output logic [num_lce_p-1:0]                  sharers_hits_o,
    output logic [num_lce_p*lg_lce_assoc_lp-1:0]  sharers_ways_o,
    output logic [num_lce_p*3-1:0]                sharers_coh_states_o
);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_read  = 2'd1,
        e_drain = 2'd2,
        e_done  = 2'd3
    } state_e;

    state_e                  state;
    logic [lg_wg_lp-1:0]     wg_r;
    logic [tag_width_p-1:0]  tag_r;
    logic [lg_rows_lp-1:0]   issue_row;
    logic                    ret_v;
    logic [lg_rows_lp-1:0]   ret_row;

    logic [lce_per_row_p-1:0]                       row_hit;
    logic [lce_per_row_p-1:0][lg_lce_assoc_lp-1:0]  row_way;
    logic [lce_per_row_p-1:0][2:0]                  row_state;
    logic [entry_w_lp-1:0]                          entry;

    assign dir_addr_o = {wg_r, issue_row};
    assign gad_v_o    = sharers_v_o;

    // Per-LCE match on the returned row; scanning ways downward lets the lowest hit win.
    always_comb begin
        row_hit   = '0;
        row_way   = '0;
        row_state = '0;
        entry     = '0;
        for (int l = 0; l < int'(lce_per_row_p); l++) begin
            for (int w = int'(lce_assoc_p) - 1; w >= 0; w--) begin
                entry = dir_data_i[(l*int'(lce_assoc_p) + w)*int'(entry_w_lp) +: entry_w_lp];
                if ((entry[tag_width_p-1:0] == tag_r) && (entry[entry_w_lp-1 -: 3] != 3'b000)) begin
                    row_hit[l]   = 1'b1;
                    row_way[l]   = lg_lce_assoc_lp'(w);
                    row_state[l] = entry[entry_w_lp-1 -: 3];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state                <= e_idle;
            ready_o              <= 1'b1;
            dir_r_v_o            <= 1'b0;
            sharers_v_o          <= 1'b0;
            wg_r                 <= '0;
            tag_r                <= '0;
            issue_row            <= '0;
            ret_v                <= 1'b0;
            ret_row              <= '0;
            sharers_hits_o       <= '0;
            sharers_ways_o       <= '0;
            sharers_coh_states_o <= '0;
        end else begin
            ret_v <= 1'b0;

            // Fold the row returned this cycle into its LCE slots.
            for (int i = 0; i < int'(num_lce_p); i++) begin
                if (ret_v && (ret_row == lg_rows_lp'(i / int'(lce_per_row_p)))) begin
                    sharers_hits_o[i]                                    <= row_hit[i % int'(lce_per_row_p)];
                    sharers_ways_o[i*int'(lg_lce_assoc_lp) +: lg_lce_assoc_lp] <= row_way[i % int'(lce_per_row_p)];
                    sharers_coh_states_o[i*3 +: 3]                       <= row_state[i % int'(lce_per_row_p)];
                end
            end

            case (state)
                e_idle: begin
                    if (start_v_i) begin
                        wg_r                 <= wg_i;
                        tag_r                <= tag_i;
                        issue_row            <= '0;
                        sharers_hits_o       <= '0;
                        sharers_ways_o       <= '0;
                        sharers_coh_states_o <= '0;
                        ready_o              <= 1'b0;
                        dir_r_v_o            <= 1'b1;
                        state                <= e_read;
                    end
                end
                e_read: begin
                    if (dir_r_ready_i) begin
                        ret_v     <= 1'b1;
                        ret_row   <= issue_row;
                        issue_row <= issue_row + lg_rows_lp'(1);
                        if (issue_row == lg_rows_lp'(rows_lp - 1)) begin
                            dir_r_v_o <= 1'b0;
                            state     <= e_drain;
                        end
                    end
                end
                e_drain: begin
                    if (ret_v) begin
                        sharers_v_o <= 1'b1;
                        state       <= e_done;
                    end
                end
                e_done: begin
                    if (yumi_i) begin
                        sharers_v_o <= 1'b0;
                        ready_o     <= 1'b1;
                        state       <= e_idle;
                    end
                end
                default: begin
                    state <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: doc/bp_cce_dir_read_seq.md
Name: bp_cce_dir_read_seq

Overview:
- Sequences a directory way-group read for the CCE.
- Issues one directory RAM row read per group of LCEs, tag-compares every returned entry against the target tag, and accumulates per-LCE hit/way/state vectors.
- Presents the result, with a GAD-valid strobe, to the auxiliary-directory-information (GAD) logic.
- Sits between the CCE instruction decode / MSHR and the directory RAM.

Parameters:
- num_lce_p, 8, number of LCEs tracked; must be a multiple of lce_per_row_p.
- lce_assoc_p, 8, ways per LCE set.
- lce_per_row_p, 2, LCEs whose full set fits in one directory RAM row.
- tag_width_p, 12, directory tag width.
- num_way_groups_p, 64, way groups in the directory.
- Derived: rows_lp = num_lce_p/lce_per_row_p; entry_w_lp = tag_width_p+3; lg_rows_lp = BSG_SAFE_CLOG2(rows_lp); lg_wg_lp = BSG_SAFE_CLOG2(num_way_groups_p); lg_lce_assoc_lp = BSG_SAFE_CLOG2(lce_assoc_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low. One clock domain.
- start_v_i  in  1  start request; accepted when start_v_i & ready_o.
- ready_o  out  1  high only in IDLE.
- wg_i  in  lg_wg_lp  target way group, captured at accept.
- tag_i  in  tag_width_p  target tag, captured at accept.
- dir_r_v_o  out  1  directory row read request.
- dir_r_ready_i  in  1  RAM accepts a read this cycle.
- dir_addr_o  out  lg_wg_lp+lg_rows_lp  {wg, row}.
- dir_data_i  in  lce_per_row_p*lce_assoc_p*entry_w_lp  row data, valid exactly one cycle after an accepted read.
- sharers_v_o  out  1  results valid; held until yumi_i.
- gad_v_o  out  1  equals sharers_v_o; drives the GAD op valid.
- yumi_i  in  1  consumer takes results.
- sharers_hits_o  out  num_lce_p  per-LCE hit.
- sharers_ways_o  out  num_lce_p*lg_lce_assoc_lp  per-LCE hit way.
- sharers_coh_states_o  out  num_lce_p*3  per-LCE bp_coh_states_e.

Behaviour:
- Reset (async assert): state=IDLE; all registers cleared; ready_o=1; dir_r_v_o=0; sharers_v_o=gad_v_o=0; all result vectors 0.
- Reset mid-operation aborts immediately. A pending RAM return is ignored.
- States:
  - IDLE: ready_o=1. On start accept, capture wg/tag, clear accumulators, set issue_row=0, go READ.
  - READ: dir_r_v_o=1, dir_addr_o={wg,issue_row}. On dir_r_ready_i, issue_row++. After accepting row rows_lp-1, go DRAIN. dir_r_ready_i low stalls; address held.
  - DRAIN: dir_r_v_o=0. Wait for the final row's data (one cycle), then go DONE.
  - DONE: sharers_v_o=gad_v_o=1, vectors stable. On yumi_i, go IDLE next cycle.
- Return tracking:
  - 1-bit ret_v register is set the cycle after each accepted read; ret_row holds that row's index.
  - When ret_v, process dir_data_i into LCE slots ret_row*lce_per_row_p .. +lce_per_row_p-1.
  - Pipelined: row k's data is processed while row k+1 is issued.
- Entry layout: entry e = l*lce_assoc_p + w occupies bits [e*entry_w_lp +: entry_w_lp]. Tag is in the low tag_width_p bits; state is in the top 3 bits.
- Hit rule: tag equals captured tag AND state != e_COH_I (0).
- Multiple hits in one LCE: the lowest way index wins, and its state is reported.
- No hit: hits=0, way=0, state=0 for that LCE.
- Latency, zero stall: accept at cycle 0, reads at cycles 1..rows_lp, sharers_v_o high at cycle rows_lp+2.
- start_v_i while not IDLE: ignored, no side effect.
- yumi_i without sharers_v_o: ignored.
- Output vectors change only while processing returns. They are cleared at accept.

Test Plan:
- Defaults, wg=5, tag=0x3A. RAM holds 0x3A in LCE 6 way 3 (state M=e_COH_M) and nothing else -> dir_addr sequence {5,0},{5,1},{5,2},{5,3}. At cycle 6: sharers_v_o=1, hits=8'b0100_0000, way[6]=3, state[6]=M, all others 0.
- LCE 2 has tag 0x3A in ways 1 (S) and 5 (E) -> hits[2]=1, way[2]=1, state[2]=S.
- Tag 0x3A present in LCE 0 way 0 with state I -> hits=0, all ways/states 0.
- dir_r_ready_i low for 3 cycles while row 2 is pending -> dir_addr_o holds {wg,2}, no duplicate returns, sharers_v_o rises at cycle 9.
- reset_n_i pulsed low during READ row 1 -> outputs zero immediately, ready_o=1. A subsequent start with tag 0x11 returns only 0x11 hits.
- start_v_i held high in DONE without yumi_i for 4 cycles -> results stable, no new reads. yumi_i -> IDLE, next start accepted one cycle later.
